// File: rtl/rr_onehot_scheduler16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_onehot_scheduler16_pkg
//  Description : Shared constants, types and helper functions for the
//                16-way round-robin one-hot scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_onehot_scheduler16_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

  // Scheduler state encodings (1-bit state register)
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0]   idx_t;

  // Rotate a request vector right by 'sh' so that bit 'sh' lands in bit 0.
  function automatic req_vec_t rotate_right(input req_vec_t v, input idx_t sh);
    logic [2*NUM_REQ-1:0] dbl;
    dbl = {v, v} >> sh;
    return dbl[NUM_REQ-1:0];
  endfunction

  // Index of the lowest set bit; 0 when no bit is set (caller qualifies with |v).
  function automatic idx_t lowest_set(input req_vec_t v);
    idx_t idx;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage : rr_onehot_scheduler16_pkg
`default_nettype wire

// File: rtl/rr_onehot_scheduler16_dec.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_dec4
//  Description : Combinational 4-bit index to 16-bit one-hot decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec4
  import rr_onehot_scheduler16_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  // One comparator per output bit; exactly one bit is high for any index.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bit
    assign onehot[i] = (idx == IDX_W'(i));
  end

endmodule : onehot_dec4
`default_nettype wire

// File: rtl/rr_onehot_scheduler16.sv
`default_nettype none
// ============================================================================
//  Module      : rr_onehot_scheduler16
//  Description : Round-robin scheduler sharing one 16-way one-hot selected
//                resource among 16 requesters. Holds each grant until the
//                owner releases it (done / request drop) or the hold timer
//                expires, then advances priority past the last owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_onehot_scheduler16
  import rr_onehot_scheduler16_pkg::*;
#(
  parameter int MAX_HOLD = 255,  // 0 disables the forced release
  parameter int CNT_W    = 8     // must satisfy 2**CNT_W > MAX_HOLD
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout
);

  // Hold-counter value on the last cycle the owner may keep the grant.
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  logic [0:0]         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_hold_cnt;

  logic [NUM_REQ-1:0] w_rot;
  logic [IDX_W-1:0]   w_offset;
  logic [IDX_W-1:0]   w_winner;
  logic               w_any_req;
  logic               w_done_hit;
  logic               w_req_hit;
  logic               w_force;
  logic               w_release;
  logic [NUM_REQ-1:0] w_dec;

  // Round-robin pick: rotate so ptr sits at bit 0, take the lowest set bit,
  // then undo the rotation (4-bit add wraps 15 -> 0 naturally).
  always_comb begin
    w_rot     = rotate_right(req, r_ptr);
    w_offset  = lowest_set(w_rot);
    w_winner  = w_offset + r_ptr;
    w_any_req = |req;
  end

  // Only the current owner's done/req bits matter while a grant is held.
  assign w_done_hit = done[grant_idx];
  assign w_req_hit  = req[grant_idx];

  if (MAX_HOLD != 0) begin : g_timeout
    assign w_force = (r_state == ST_BUSY) && (r_hold_cnt == C_HOLD_LAST);
  end else begin : g_no_timeout
    assign w_force = 1'b0;
  end

  assign w_release = w_done_hit || !w_req_hit || w_force;

  // Arbitration / hold state machine; grant_idx keeps the last owner after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          grant_valid <= 1'b0;
          if (en && w_any_req) begin
            grant_idx   <= w_winner;
            grant_valid <= 1'b1;
            r_hold_cnt  <= '0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_hold_cnt != '1) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
          if (w_release) begin
            grant_valid <= 1'b0;
            r_ptr       <= grant_idx + 1'b1;
            r_state     <= ST_IDLE;
            // A simultaneous done makes this an ordinary release.
            timeout     <= w_force && !w_done_hit;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  onehot_dec4 u_dec (
    .idx    (grant_idx),
    .onehot (w_dec)
  );

  // Gating with grant_valid makes the grant drop as soon as reset asserts.
  assign grant = w_dec & {NUM_REQ{grant_valid}};

endmodule : rr_onehot_scheduler16
`default_nettype wire

// File: tb/tb_rr_onehot_scheduler16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_onehot_scheduler16
//  Description : Self-checking bench for the 16-way round-robin scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_onehot_scheduler16;

  localparam int MAX_HOLD = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] req;
  logic [15:0] done;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int vectors;
  int miscompares;

  rr_onehot_scheduler16 #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner, cycles the grant has been visible, next-priority index.
  logic        m_valid;
  logic [3:0]  m_idx;
  logic [3:0]  m_ptr;
  int          m_held;
  logic        m_timeout;
  logic [15:0] m_grant;

  assign m_grant = m_valid ? (16'h0001 << m_idx) : 16'h0000;

  // First requester found walking upward from p, wrapping past 15.
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] p);
    int n;
    for (int k = 0; k < 16; k++) begin
      n = (int'(p) + k) % 16;
      if (r[n]) return 4'(n);
    end
    return 4'(0);
  endfunction

  // Model advances on the same edges as the design.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_idx     <= 4'h0;
      m_ptr     <= 4'h0;
      m_held    <= 0;
      m_timeout <= 1'b0;
    end else begin
      m_timeout <= 1'b0;
      if (!m_valid) begin
        if (en && req != 16'h0000) begin
          m_idx   <= rr_pick(req, m_ptr);
          m_valid <= 1'b1;
          m_held  <= 1;
        end
      end else if (done[m_idx] || !req[m_idx] || (MAX_HOLD != 0 && m_held == MAX_HOLD)) begin
        m_valid   <= 1'b0;
        m_ptr     <= m_idx + 4'd1;
        m_timeout <= !done[m_idx] && (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      end else begin
        m_held <= m_held + 1;
      end
    end
  end

  task automatic do_reset();
    rst  = 1'b1;
    en   = 1'b1;
    req  = 16'h0000;
    done = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b1;
    req  = 16'h0000;
    done = 16'h0000;
    #1;
    vectors++;
    if ({grant, grant_idx, grant_valid, timeout} !== 22'h0) begin
      miscompares++;
      $display("FAIL reset_state: grant=%h idx=%h v=%b to=%b, expected all zero",
               grant, grant_idx, grant_valid, timeout);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (grant !== 16'h0000 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_no_req c=%0d: grant=%h v=%b to=%b, expected 0000/0/0",
                 c, grant, grant_valid, timeout);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] seen[$];
    logic [15:0] exp_seq[3];
    logic        prev_v;
    exp_seq = '{16'h0001, 16'h0020, 16'h0001};
    prev_v  = 1'b0;
    do_reset();
    req = 16'h0021;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if ({grant, grant_idx, grant_valid, timeout} !== {m_grant, m_idx, m_valid, m_timeout}) begin
        miscompares++;
        $display("FAIL rr_model c=%0d: grant=%h idx=%h v=%b to=%b, expected %h %h %b %b",
                 c, grant, grant_idx, grant_valid, timeout, m_grant, m_idx, m_valid, m_timeout);
      end
      if (grant_valid && !prev_v) seen.push_back(grant);
      prev_v = grant_valid;
      done = (m_valid && m_held == 3) ? m_grant : 16'h0000;
    end
    done = 16'h0000;
    vectors++;
    if (seen.size() < 3) begin
      miscompares++;
      $display("FAIL rr_count: %0d grants seen, expected at least 3", seen.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (seen[i] !== exp_seq[i]) begin
          miscompares++;
          $display("FAIL rr_order[%0d]: grant=%h, expected %h", i, seen[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] seen[$];
    logic [15:0] exp_seq[3];
    logic        prev_v;
    exp_seq = '{16'h4000, 16'h8000, 16'h0001};
    prev_v  = 1'b0;
    do_reset();
    req = 16'h4000;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      vectors++;
      if ({grant, grant_idx, grant_valid, timeout} !== {m_grant, m_idx, m_valid, m_timeout}) begin
        miscompares++;
        $display("FAIL wrap_model c=%0d: grant=%h idx=%h v=%b to=%b, expected %h %h %b %b",
                 c, grant, grant_idx, grant_valid, timeout, m_grant, m_idx, m_valid, m_timeout);
      end
      if (grant_valid && !prev_v) seen.push_back(grant);
      prev_v = grant_valid;
      if (m_valid && m_idx == 4'd14 && m_held == 2) req = 16'h8001;
      done = (m_valid && m_idx != 4'd14 && m_held == 2) ? m_grant : 16'h0000;
    end
    done = 16'h0000;
    vectors++;
    if (seen.size() < 3) begin
      miscompares++;
      $display("FAIL wrap_count: %0d grants seen, expected at least 3", seen.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (seen[i] !== exp_seq[i]) begin
          miscompares++;
          $display("FAIL wrap_order[%0d]: grant=%h, expected %h", i, seen[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] g[9];
    logic        t[9];
    do_reset();
    req = 16'h0004;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      g[c] = grant;
      t[c] = timeout;
      vectors++;
      if ({grant, grant_idx, grant_valid, timeout} !== {m_grant, m_idx, m_valid, m_timeout}) begin
        miscompares++;
        $display("FAIL to_model c=%0d: grant=%h idx=%h v=%b to=%b, expected %h %h %b %b",
                 c, grant, grant_idx, grant_valid, timeout, m_grant, m_idx, m_valid, m_timeout);
      end
    end
    for (int c = 1; c <= 4; c++) begin
      vectors++;
      if (g[c] !== 16'h0004 || t[c] !== 1'b0) begin
        miscompares++;
        $display("FAIL to_hold c=%0d: grant=%h to=%b, expected 0004/0", c, g[c], t[c]);
      end
    end
    vectors++;
    if (g[5] !== 16'h0000 || t[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL to_drop: grant=%h to=%b, expected 0000/1", g[5], t[5]);
    end
    vectors++;
    if (g[6] !== 16'h0004 || t[6] !== 1'b0) begin
      miscompares++;
      $display("FAIL to_regrant: grant=%h to=%b, expected 0004/0", g[6], t[6]);
    end
    req = 16'h0000;
  endtask

  task automatic test_enable();
    do_reset();
    en  = 1'b0;
    req = 16'hFFFF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (grant !== 16'h0000 || grant_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL en_block c=%0d: grant=%h v=%b, expected 0000/0", c, grant, grant_valid);
      end
    end
    en = 1'b1;
    @(negedge clk);
    vectors++;
    if (grant !== 16'h0001) begin
      miscompares++;
      $display("FAIL en_grant: grant=%h, expected 0001", grant);
    end
    en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (grant !== 16'h0001) begin
        miscompares++;
        $display("FAIL en_hold c=%0d: grant=%h, expected 0001", c, grant);
      end
    end
    done = 16'h0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      done = 16'h0000;
      vectors++;
      if (grant !== 16'h0000 || {grant, grant_idx, grant_valid, timeout} !==
          {m_grant, m_idx, m_valid, m_timeout}) begin
        miscompares++;
        $display("FAIL en_after_done c=%0d: grant=%h idx=%h v=%b to=%b, expected 0000 %h %b %b",
                 c, grant, grant_idx, grant_valid, timeout, m_idx, m_valid, m_timeout);
      end
    end
    en  = 1'b1;
    req = 16'h0000;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 16'h0008;
    @(negedge clk);
    vectors++;
    if (grant !== 16'h0008) begin
      miscompares++;
      $display("FAIL rm_first: grant=%h, expected 0008", grant);
    end
    req = 16'h0100;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (grant !== 16'h0100) begin
      miscompares++;
      $display("FAIL rm_busy: grant=%h, expected 0100", grant);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (grant !== 16'h0000 || grant_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_async_drop: grant=%h v=%b, expected 0000/0", grant, grant_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 16'h0108;
    @(negedge clk);
    vectors++;
    if (grant !== 16'h0008) begin
      miscompares++;
      $display("FAIL rm_ptr_restart: grant=%h, expected 0008", grant);
    end
    done = 16'h0008;
    @(negedge clk);
    done = 16'h0000;
    @(negedge clk);
    vectors++;
    if (grant !== 16'h0100) begin
      miscompares++;
      $display("FAIL rm_regrant: grant=%h, expected 0100", grant);
    end
    req = 16'h0000;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      vectors++;
      if ({grant, grant_idx, grant_valid, timeout} !== {m_grant, m_idx, m_valid, m_timeout}) begin
        miscompares++;
        $display("FAIL rand_model c=%0d: grant=%h idx=%h v=%b to=%b, expected %h %h %b %b",
                 c, grant, grant_idx, grant_valid, timeout, m_grant, m_idx, m_valid, m_timeout);
      end
      vectors++;
      if (!$onehot0(grant) || ((grant != 16'h0000) !== grant_valid)) begin
        miscompares++;
        $display("FAIL rand_invariant c=%0d: grant=%h v=%b", c, grant, grant_valid);
      end
      if ($urandom_range(0, 3) == 0) begin
        req = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom & $urandom);
      end
      done = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0000;
      en   = ($urandom_range(0, 7) != 0);
    end
    req  = 16'h0000;
    done = 16'h0000;
    en   = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_enable();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_rr_onehot_scheduler16
`default_nettype wire
